// File: rtl/storage_int_seq_pkg.sv
// Shared MSR bit indices, interrupt vectors, cause masks and sequencer state encodings.
// ST_RFI exists only when STORAGE_INT_RFI_EN is defined.
package storage_int_seq_pkg;

    // MSR bit positions, MSB-0 numbering
    localparam int MSR_EE = 16;
    localparam int MSR_PR = 17;
    localparam int MSR_IP = 25;
    localparam int MSR_IR = 26;
    localparam int MSR_DR = 27;

    localparam logic [0:31] VEC_DSI_OFS   = 32'h0000_0300;
    localparam logic [0:31] VEC_ISI_OFS   = 32'h0000_0400;
    localparam logic [0:31] VEC_HIGH_BASE = 32'hFFF0_0000;
    localparam logic [0:31] CAUSE_PROT    = 32'h0800_0000;
    localparam logic [0:31] CAUSE_STORE   = 32'h0200_0000;
    localparam logic [0:31] RFI_PC_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_SAVE  = 3'd2,
        ST_VECT  = 3'd3,
        ST_ACK   = 3'd4
`ifdef STORAGE_INT_RFI_EN
        , ST_RFI = 3'd5
`endif
    } state_e;

    typedef enum logic {
        CAUSE_DSI = 1'b0,
        CAUSE_ISI = 1'b1
    } cause_e;

    // Interrupt entry runs untranslated, in supervisor mode, with external interrupts masked.
    function automatic logic [0:31] msr_on_int(input logic [0:31] msr);
        logic [0:31] m;
        m         = msr;
        m[MSR_EE] = 1'b0;
        m[MSR_PR] = 1'b0;
        m[MSR_IR] = 1'b0;
        m[MSR_DR] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/int_spr_file.sv
// Save/restore SPRs (SRR0, SRR1, DAR, DSISR) with one write enable per register.
module int_spr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        srr0_we,
    input  logic [0:31] srr0_wd,
    input  logic        srr1_we,
    input  logic [0:31] srr1_wd,
    input  logic        dar_we,
    input  logic [0:31] dar_wd,
    input  logic        dsisr_we,
    input  logic [0:31] dsisr_wd,
    output logic [0:31] srr0,
    output logic [0:31] srr1,
    output logic [0:31] dar,
    output logic [0:31] dsisr
);

    logic [0:31] srr0_d, srr0_q;
    logic [0:31] srr1_d, srr1_q;
    logic [0:31] dar_d, dar_q;
    logic [0:31] dsisr_d, dsisr_q;

    always_comb begin
        srr0_d  = srr0_we  ? srr0_wd  : srr0_q;
        srr1_d  = srr1_we  ? srr1_wd  : srr1_q;
        dar_d   = dar_we   ? dar_wd   : dar_q;
        dsisr_d = dsisr_we ? dsisr_wd : dsisr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            srr0_q  <= '0;
            srr1_q  <= '0;
            dar_q   <= '0;
            dsisr_q <= '0;
        end else begin
            srr0_q  <= srr0_d;
            srr1_q  <= srr1_d;
            dar_q   <= dar_d;
            dsisr_q <= dsisr_d;
        end
    end

    assign srr0  = srr0_q;
    assign srr1  = srr1_q;
    assign dar   = dar_q;
    assign dsisr = dsisr_q;

endmodule

// File: rtl/storage_int_seq.sv
// Storage-interrupt sequencer: DSI/ISI entry (flush, save, vector, ack) and optional rfi return.
// Define STORAGE_INT_RFI_EN to build the rfi path; otherwise rfi_req is ignored.
//
// state | meaning
// IDLE  | waiting for dsi/isi (or rfi_req)
// FLUSH | flush pulse, cause held
// SAVE  | SRR0/SRR1 (and DAR/DSISR on DSI) load at end of cycle
// VECT  | PC redirect to vector, MSR write
// ACK   | clear pulse to detector(s)
// RFI   | single-cycle return: flush, redirect to SRR0, MSR <- SRR1
module storage_int_seq
    import storage_int_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dsi,
    input  logic        isi,
    input  logic [0:31] dsi_pc,
    input  logic [0:31] dsi_ea,
    input  logic        dsi_store,
    input  logic [0:31] isi_pc,
    input  logic [0:31] MSR,
    input  logic        rfi_req,
    output logic        ack_dsi,
    output logic        ack_isi,
    output logic        rfi_ack,
    output logic        busy,
    output logic        flush,
    output logic        npc_we,
    output logic [0:31] npc,
    output logic        msr_we,
    output logic [0:31] msr_nxt,
    output logic [0:31] SRR0,
    output logic [0:31] SRR1,
    output logic [0:31] DAR,
    output logic [0:31] DSISR
);

    state_e      state_d, state_q;
    cause_e      cause_d, cause_q;
    logic        flush_d, flush_q;
    logic        busy_d, busy_q;
    logic        npc_we_d, npc_we_q;
    logic        msr_we_d, msr_we_q;
    logic        ack_dsi_d, ack_dsi_q;
    logic        ack_isi_d, ack_isi_q;
    logic        rfi_ack_d, rfi_ack_q;
    logic [0:31] npc_d, npc_q;
    logic [0:31] msr_nxt_d, msr_nxt_q;

    logic        spr_we;
    logic        spr_dsi_we;
    logic [0:31] srr0_wd;
    logic [0:31] srr1_wd;
    logic [0:31] dsisr_wd;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        flush_d   = 1'b0;
        busy_d    = 1'b0;
        npc_we_d  = 1'b0;
        msr_we_d  = 1'b0;
        ack_dsi_d = 1'b0;
        ack_isi_d = 1'b0;
        rfi_ack_d = 1'b0;
        npc_d     = '0;
        msr_nxt_d = '0;
        case (state_q)
            ST_IDLE: begin
                // dsi wins: the faulting load/store is older than the faulting fetch
                if (dsi) begin
                    state_d = ST_FLUSH;
                    cause_d = CAUSE_DSI;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (isi) begin
                    state_d = ST_FLUSH;
                    cause_d = CAUSE_ISI;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end
`ifdef STORAGE_INT_RFI_EN
                else if (rfi_req) begin
                    state_d   = ST_RFI;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                    npc_we_d  = 1'b1;
                    msr_we_d  = 1'b1;
                    rfi_ack_d = 1'b1;
                    npc_d     = SRR0 & RFI_PC_MASK;
                    msr_nxt_d = SRR1;
                end
`endif
            end
            ST_FLUSH: begin
                state_d = ST_SAVE;
                busy_d  = 1'b1;
            end
            ST_SAVE: begin
                state_d   = ST_VECT;
                busy_d    = 1'b1;
                npc_we_d  = 1'b1;
                msr_we_d  = 1'b1;
                npc_d     = (MSR[MSR_IP] ? VEC_HIGH_BASE : 32'h0)
                          + ((cause_q == CAUSE_DSI) ? VEC_DSI_OFS : VEC_ISI_OFS);
                msr_nxt_d = msr_on_int(MSR);
            end
            ST_VECT: begin
                // a DSI also drops any ISI raised by the younger, now-flushed fetch
                state_d   = ST_ACK;
                busy_d    = 1'b1;
                ack_dsi_d = (cause_q == CAUSE_DSI);
                ack_isi_d = 1'b1;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_DSI;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            npc_we_q  <= 1'b0;
            msr_we_q  <= 1'b0;
            ack_dsi_q <= 1'b0;
            ack_isi_q <= 1'b0;
            rfi_ack_q <= 1'b0;
            npc_q     <= '0;
            msr_nxt_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            flush_q   <= flush_d;
            busy_q    <= busy_d;
            npc_we_q  <= npc_we_d;
            msr_we_q  <= msr_we_d;
            ack_dsi_q <= ack_dsi_d;
            ack_isi_q <= ack_isi_d;
            rfi_ack_q <= rfi_ack_d;
            npc_q     <= npc_d;
            msr_nxt_q <= msr_nxt_d;
        end
    end

    always_comb begin
        spr_we     = (state_q == ST_SAVE);
        spr_dsi_we = spr_we && (cause_q == CAUSE_DSI);
        srr0_wd    = (cause_q == CAUSE_DSI) ? dsi_pc : isi_pc;
        srr1_wd    = (cause_q == CAUSE_DSI) ? MSR : (MSR | CAUSE_PROT);
        dsisr_wd   = CAUSE_PROT | (dsi_store ? CAUSE_STORE : 32'h0);
    end

    int_spr_file u_spr (
        .clk      (clk),
        .rst      (rst),
        .srr0_we  (spr_we),
        .srr0_wd  (srr0_wd),
        .srr1_we  (spr_we),
        .srr1_wd  (srr1_wd),
        .dar_we   (spr_dsi_we),
        .dar_wd   (dsi_ea),
        .dsisr_we (spr_dsi_we),
        .dsisr_wd (dsisr_wd),
        .srr0     (SRR0),
        .srr1     (SRR1),
        .dar      (DAR),
        .dsisr    (DSISR)
    );

    assign busy    = busy_q || ((state_q == ST_IDLE) && (dsi || isi));
    assign flush   = flush_q;
    assign npc_we  = npc_we_q;
    assign msr_we  = msr_we_q;
    assign npc     = npc_q;
    assign msr_nxt = msr_nxt_q;
    assign ack_dsi = ack_dsi_q;
    assign ack_isi = ack_isi_q;
    assign rfi_ack = rfi_ack_q;

endmodule

// File: tb/tb_storage_int_seq.sv
// Scoreboard bench for storage_int_seq: stimulus pushes expected strobe events and idle snapshots,
// a negedge monitor pops and compares. rfi expectations follow STORAGE_INT_RFI_EN.
module tb_storage_int_seq;

    typedef struct packed {
        logic [31:0] cyc;
        logic        busy;
        logic        flush;
        logic        npc_we;
        logic        msr_we;
        logic        ack_dsi;
        logic        ack_isi;
        logic        rfi_ack;
        logic [31:0] npc;
        logic [31:0] msr_nxt;
        logic [31:0] srr0;
        logic [31:0] srr1;
        logic [31:0] dar;
        logic [31:0] dsisr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dsi = 1'b0;
    logic        isi = 1'b0;
    logic        dsi_store = 1'b0;
    logic        rfi_req = 1'b0;
    logic [31:0] dsi_pc = '0;
    logic [31:0] dsi_ea = '0;
    logic [31:0] isi_pc = '0;
    logic [31:0] msr = '0;

    logic        ack_dsi, ack_isi, rfi_ack, busy, flush, npc_we, msr_we;
    logic [31:0] npc, msr_nxt, srr0, srr1, dar, dsisr;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    ev_t strb_q[$];
    ev_t snap_q[$];

    logic [31:0] m_srr0 = '0, m_srr1 = '0, m_dar = '0, m_dsisr = '0;

    storage_int_seq dut (
        .clk       (clk),
        .rst       (rst),
        .dsi       (dsi),
        .isi       (isi),
        .dsi_pc    (dsi_pc),
        .dsi_ea    (dsi_ea),
        .dsi_store (dsi_store),
        .isi_pc    (isi_pc),
        .MSR       (msr),
        .rfi_req   (rfi_req),
        .ack_dsi   (ack_dsi),
        .ack_isi   (ack_isi),
        .rfi_ack   (rfi_ack),
        .busy      (busy),
        .flush     (flush),
        .npc_we    (npc_we),
        .npc       (npc),
        .msr_we    (msr_we),
        .msr_nxt   (msr_nxt),
        .SRR0      (srr0),
        .SRR1      (srr1),
        .DAR       (dar),
        .DSISR     (dsisr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic b, input logic fl, input logic nw,
                               input logic mw, input logic ad, input logic ai, input logic ra,
                               input logic [31:0] pc, input logic [31:0] mn,
                               input logic [31:0] s0, input logic [31:0] s1,
                               input logic [31:0] da, input logic [31:0] ds);
        ev_t e;
        e.cyc = c; e.busy = b; e.flush = fl; e.npc_we = nw; e.msr_we = mw;
        e.ack_dsi = ad; e.ack_isi = ai; e.rfi_ack = ra; e.npc = pc; e.msr_nxt = mn;
        e.srr0 = s0; e.srr1 = s1; e.dar = da; e.dsisr = ds;
        return e;
    endfunction

    // Monitor: every strobe cycle pops the strobe queue; snapshot entries are checked on their cycle.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        act = mk(cyc, busy, flush, npc_we, msr_we, ack_dsi, ack_isi, rfi_ack,
                 npc, msr_nxt, srr0, srr1, dar, dsisr);
        if (flush || npc_we || msr_we || ack_dsi || ack_isi || rfi_ack) begin
            total++;
            if (strb_q.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected cyc=%0d got=%h want=none", cyc, act);
            end else begin
                exp = strb_q.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL strobe cyc=%0d got=%h want=%h", cyc, act, exp);
                end
            end
        end
        if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            exp = snap_q.pop_front();
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL snapshot cyc=%0d got=%h want=%h", cyc, act, exp);
            end
        end
    end

    // One cycle; sticky requests drop one cycle after the ack is seen, like the detectors.
    task automatic tick();
        logic ad, ai, ra;
        @(negedge clk);
        ad = ack_dsi;
        ai = ack_isi;
        ra = rfi_ack;
        @(posedge clk);
        #1;
        if (ad) dsi = 1'b0;
        if (ai) isi = 1'b0;
        if (ra) rfi_req = 1'b0;
    endtask

    // Called in the cycle the request is first visible; pushes the whole expected sequence.
    task automatic run_int(input bit is_dsi, input bit late_isi, input bit abort_in_vect);
        int c;
        logic [31:0] n0, n1, nd, nds, pc, mn;
        c   = cyc;
        n0  = is_dsi ? dsi_pc : isi_pc;
        n1  = is_dsi ? msr : (msr | 32'h0800_0000);
        nd  = is_dsi ? dsi_ea : m_dar;
        nds = is_dsi ? (32'h0800_0000 | (dsi_store ? 32'h0200_0000 : 32'h0)) : m_dsisr;
        pc  = (((msr & 32'h0000_0040) != 0) ? 32'hFFF0_0000 : 32'h0)
            + (is_dsi ? 32'h0000_0300 : 32'h0000_0400);
        mn  = msr & 32'hFFFF_3FCF;
        snap_q.push_back(mk(c, 1, 0, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        strb_q.push_back(mk(c + 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        snap_q.push_back(mk(c + 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        strb_q.push_back(mk(c + 3, 1, 0, 1, 1, 0, 0, 0, pc, mn, n0, n1, nd, nds));
        if (abort_in_vect) begin
            m_srr0 = '0; m_srr1 = '0; m_dar = '0; m_dsisr = '0;
            snap_q.push_back(mk(c + 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            repeat (3) tick();
            rst = 1'b1;
            dsi = 1'b0;
            isi = 1'b0;
            tick();
            rst = 1'b0;
            repeat (4) tick();
        end else begin
            strb_q.push_back(mk(c + 4, 1, 0, 0, 0, is_dsi, 1, 0, 0, 0, n0, n1, nd, nds));
            snap_q.push_back(mk(c + 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, n0, n1, nd, nds));
            m_srr0 = n0; m_srr1 = n1; m_dar = nd; m_dsisr = nds;
            for (int k = 0; k < 9; k++) begin
                tick();
                if (late_isi && cyc == c + 2) isi = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        repeat (3) tick();
        rst = 1'b0;
        snap_q.push_back(mk(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) tick();

        // DSI on a store with PR/EE/IR/DR set
        dsi_pc = 32'h0000_1000; dsi_ea = 32'h8000_0004; dsi_store = 1'b1; msr = 32'h0000_C030;
        dsi = 1'b1;
        run_int(1, 0, 0);

        // ISI with high vectors
        isi_pc = 32'h0000_2000; msr = 32'h0000_C070;
        isi = 1'b1;
        run_int(0, 0, 0);

        // simultaneous DSI and ISI: only the DSI sequence, both acks
        dsi_pc = 32'h0000_3000; dsi_ea = 32'h1234_5678; dsi_store = 1'b0;
        isi_pc = 32'h5555_0000; msr = 32'h0000_C030;
        dsi = 1'b1; isi = 1'b1;
        run_int(1, 0, 0);

        // ISI arriving mid-DSI is swallowed by the DSI ack
        dsi_pc = 32'h0000_4000; dsi_ea = 32'h0000_0ABC; dsi_store = 1'b1;
        isi_pc = 32'h0000_6000; msr = 32'h0000_8030;
        dsi = 1'b1;
        run_int(1, 1, 0);

        // load SRR0=0x1007, SRR1=0x8000 for the rfi check
        dsi_pc = 32'h0000_1007; dsi_ea = 32'h0000_0040; dsi_store = 1'b0; msr = 32'h0000_8000;
        dsi = 1'b1;
        run_int(1, 0, 0);

        c = cyc;
        rfi_req = 1'b1;
`ifdef STORAGE_INT_RFI_EN
        strb_q.push_back(mk(c + 1, 1, 1, 1, 1, 0, 0, 1, m_srr0 & 32'hFFFF_FFFC, m_srr1,
                            m_srr0, m_srr1, m_dar, m_dsisr));
        snap_q.push_back(mk(c + 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        repeat (6) tick();
`else
        snap_q.push_back(mk(c + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        snap_q.push_back(mk(c + 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_srr0, m_srr1, m_dar, m_dsisr));
        repeat (6) tick();
        rfi_req = 1'b0;
        tick();
`endif

        // reset in VECT: sequence aborts, no ack, SPRs cleared
        dsi_pc = 32'h0000_7000; dsi_ea = 32'h0000_7777; dsi_store = 1'b0; msr = 32'h0000_C030;
        dsi = 1'b1;
        run_int(1, 0, 1);

        repeat (3) tick();
        while (strb_q.size() > 0) begin
            ev_t e;
            e = strb_q.pop_front();
            total++;
            bad++;
            $display("FAIL strobe_missing got=none want=%h", e);
        end
        while (snap_q.size() > 0) begin
            ev_t e;
            e = snap_q.pop_front();
            total++;
            bad++;
            $display("FAIL snapshot_missing got=none want=%h", e);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
